// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the MEM-stage access controller
package pipeline_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Low address bits that must be zero for a word access
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - req/ack data-memory bus between controller and memory
interface mem_access_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/access_timer.sv
// rtl/access_timer.sv - counts BUSY cycles without ack and flags the final one
module access_timer #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Asserted during the TIMEOUT-th consecutive BUSY cycle without ack
  assign expired = enable && (count == LAST);
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage word load/store sequencer with stall,
// misalignment and ack-timeout reporting
module mem_access_ctrl
  import pipeline_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              stall,
  mem_access_ctrl_if.master bus,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              err_misalign,
  output logic              err_timeout
);
  state_t state;
  logic   req_any;
  logic   misaligned;
  logic   timer_clear;
  logic   timer_en;
  logic   expired;

  assign req_any     = MemRead | MemWrite;
  assign misaligned  = |(alu_result[1:0] & WORD_ALIGN_MASK);
  assign timer_clear = (state == IDLE) && req_any;
  assign timer_en    = (state == BUSY) && !bus.mem_ack;

  access_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  // Reset gates stall so the pipeline is released the same instant
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = req_any;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
    stall = stall & reset_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      load_data     <= '0;
      load_valid    <= 1'b0;
      err_misalign  <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      load_valid   <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            if (misaligned) begin
              err_misalign <= 1'b1;
              state        <= DONE;
            end else begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= MemWrite;
              bus.mem_addr  <= alu_result;
              bus.mem_wdata <= rs2_data;
              state         <= BUSY;
            end
          end
        end
        BUSY: begin
          // An ack in the last timeout cycle wins because it disables the timer
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (!bus.mem_we) begin
              load_data  <= bus.mem_rdata;
              load_valid <= 1'b1;
            end
            state <= DONE;
          end else if (expired) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            load_data   <= '0;
            err_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
